// File: rtl/wirelog_pkg.sv
// Shared types and width helpers for the wire-logic trigger path.
// Imported by the emitter and its trigger queue.
package wirelog_pkg;

    typedef enum logic {
        ARM,
        RUN
    } emitter_state_t;

    localparam int DEF_GATE_COUNT = 8;
    localparam int DEF_IDX_W      = $clog2(DEF_GATE_COUNT);

    typedef logic [DEF_IDX_W-1:0] trig_idx_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/trigger_fifo.sv
// Synchronous FIFO for trigger indices; push while full is taken
// only when a pop retires the head in the same cycle.
module trigger_fifo
    import wirelog_pkg::*;
#(
    parameter  int WIDTH = DEF_IDX_W,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // storage needs no reset; empty gates the output
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gate_trigger_emitter.sv
// Turns gate output changes into one trigger index per accepted
// cycle, lowest index first, with a per-gate pending mask.
module gate_trigger_emitter
    import wirelog_pkg::*;
#(
    parameter  int GATE_COUNT = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDX_W      = idx_width(GATE_COUNT),
    localparam int CNT_W      = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  logic_reset,
    input  logic [GATE_COUNT-1:0] gate_out,
    output logic                  trig_valid,
    input  logic                  trig_ready,
    output logic [IDX_W-1:0]      trig_idx,
    output logic                  busy,
    output logic [CNT_W-1:0]      pending_cnt
);

    emitter_state_t        state;
    emitter_state_t        state_nxt;
    logic [GATE_COUNT-1:0] prev;
    logic [GATE_COUNT-1:0] pending;
    logic [GATE_COUNT-1:0] changed;
    logic [GATE_COUNT-1:0] pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_hit;
    logic                  push;
    logic                  pop;
    logic                  q_full;
    logic                  q_empty;

    always_ff @(posedge clk) begin
        if (logic_reset) state <= ARM;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        changed   = '0;
        unique case (state)
            ARM: state_nxt = RUN;
            RUN: changed   = gate_out ^ prev;
            default: state_nxt = ARM;
        endcase
    end

    always_comb begin
        pick_idx = '0;
        pick_hit = 1'b0;
        for (int i = GATE_COUNT - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_idx = IDX_W'(i);
                pick_hit = 1'b1;
            end
        end
    end

    assign pop         = trig_valid && trig_ready;
    assign push        = pick_hit && (!q_full || pop);
    assign pick_onehot = push ? (GATE_COUNT'(1) << pick_idx) : '0;

    // a second toggle before pick cancels; a toggle on the pick edge re-arms
    always_ff @(posedge clk) begin
        if (logic_reset) begin
            prev    <= '0;
            pending <= '0;
        end else begin
            prev    <= gate_out;
            pending <= (pending & ~pick_onehot) ^ changed;
        end
    end

    trigger_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (logic_reset),
        .push  (push),
        .din   (pick_idx),
        .pop   (pop),
        .dout  (trig_idx),
        .full  (q_full),
        .empty (q_empty),
        .count (pending_cnt)
    );

    assign trig_valid = !q_empty;
    assign busy       = (|pending) || !q_empty;

endmodule
